// File: rtl/pe_inject_ni_pkg.sv
// Shared flit format and per-VC packet state for the PE injection interface.
package pe_inject_ni_pkg;
  localparam int DATAW    = 31;  // flit MSB index
  localparam int VCHW     = 0;   // VC id MSB index
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;

  typedef enum logic [1:0] {
    TYPE_BODY     = 2'd0,
    TYPE_HEAD     = 2'd1,
    TYPE_TAIL     = 2'd2,
    TYPE_HEADTAIL = 2'd3
  } flit_type_e;

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} vc_state_e;
endpackage

// File: rtl/pe_inject_ni_if.sv
// PE-facing send handshake plus router-facing flit/credit bus of the NI.
interface pe_inject_ni_if import pe_inject_ni_pkg::*; #(parameter int VCH = 2);
  logic           req;
  logic           grt;
  logic [DATAW:0] idata;
  logic           ivalid;
  logic [VCHW:0]  ivch;
  logic [DATAW:0] odata;
  logic           ovalid;
  logic [VCHW:0]  ovch;
  logic [VCH-1:0] icredit;

  modport master (output req, idata, ivalid, ivch, icredit,
                  input  grt, odata, ovalid, ovch);
  modport slave  (input  req, idata, ivalid, ivch, icredit,
                  output grt, odata, ovalid, ovch);
endinterface

// File: rtl/pe_inject_ni_fifo.sv
// Per-VC synchronous FIFO; reads are combinational from the head slot, no write bypass.
module ni_vc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wdata,
  input  logic         rd_en,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  free
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, count;

  // Extra pointer bit distinguishes full from empty.
  assign count = wr_ptr - rd_ptr;
  assign full  = count == DEPTH_W;
  assign empty = count == '0;
  assign free  = DEPTH_W - count;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/pe_inject_ni.sv
// Local-port injection NI: grants the PE, buffers flits per VC, forwards round-robin under credits.
module pe_inject_ni import pe_inject_ni_pkg::*; #(
  parameter int VCH     = 2,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  localparam int FW     = $clog2(DEPTH) + 1,
  localparam int CW     = $clog2(CREDITS + 1),
  localparam int PW     = (VCH > 1) ? $clog2(VCH) : 1
) (
  input  logic        clk,
  input  logic        rst,
  pe_inject_ni_if.slave ni,
  output logic [15:0] pkt_cnt,
  output logic        err
);
  logic [VCH-1:0][DATAW:0] rdata;
  logic [VCH-1:0][FW-1:0]  free;
  logic [VCH-1:0][CW-1:0]  credit;
  logic [VCH-1:0]          full, empty, wr, rd, elig;
  vc_state_e               state [VCH];
  logic [PW-1:0]           rr, win;
  logic                    send, roomy, drop, in_start;
  flit_type_e              in_type, out_type;

  // Two free slots per VC absorb flits the PE already has in flight.
  always_comb begin
    roomy = 1'b1;
    for (int v = 0; v < VCH; v++)
      if (free[v] < FW'(2)) roomy = 1'b0;
  end
  assign ni.grt = ni.req && roomy;

  assign in_type  = flit_type_e'(ni.idata[TYPE_MSB:TYPE_LSB]);
  assign in_start = (in_type == TYPE_HEAD) || (in_type == TYPE_HEADTAIL);
  assign out_type = flit_type_e'(rdata[win][TYPE_MSB:TYPE_LSB]);
  assign drop     = ni.ivalid && !(|wr);

  for (genvar v = 0; v < VCH; v++) begin : g_vc
    // A full FIFO still accepts when it is being read in the same cycle.
    assign wr[v]   = ni.ivalid && (int'(ni.ivch) == v) && (!full[v] || rd[v]);
    assign rd[v]   = send && (int'(win) == v);
    assign elig[v] = !empty[v] && (credit[v] != '0);

    ni_vc_fifo #(.W(DATAW + 1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr[v]),
      .wdata (ni.idata),
      .rd_en (rd[v]),
      .rdata (rdata[v]),
      .full  (full[v]),
      .empty (empty[v]),
      .free  (free[v])
    );
  end

  // Scan from the highest offset down so the closest eligible VC after rr wins.
  always_comb begin
    send = 1'b0;
    win  = rr;
    for (int i = VCH - 1; i >= 0; i--) begin
      if (elig[(int'(rr) + i) % VCH]) begin
        send = 1'b1;
        win  = PW'((int'(rr) + i) % VCH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ni.odata  <= '0;
      ni.ovalid <= 1'b0;
      ni.ovch   <= '0;
      pkt_cnt   <= '0;
      err       <= 1'b0;
      rr        <= '0;
      for (int v = 0; v < VCH; v++) begin
        credit[v] <= CW'(CREDITS);
        state[v]  <= IDLE;
      end
    end else begin
      ni.ovalid <= send;
      if (send) begin
        ni.odata <= rdata[win];
        ni.ovch  <= (VCHW+1)'(win);
        rr       <= PW'((int'(win) + 1) % VCH);
        if (out_type == TYPE_TAIL || out_type == TYPE_HEADTAIL) pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (drop) err <= 1'b1;
      for (int v = 0; v < VCH; v++) begin
        // Mis-sequenced flits are kept; the FSM resynchronises to the flit type.
        if (wr[v]) begin
          if ((state[v] == PKT) == in_start) err <= 1'b1;
          state[v] <= (in_type == TYPE_HEAD || in_type == TYPE_BODY) ? PKT : IDLE;
        end
        if (rd[v] && !ni.icredit[v]) begin
          credit[v] <= credit[v] - 1'b1;
        end else if (ni.icredit[v] && !rd[v]) begin
          if (credit[v] == CW'(CREDITS)) err <= 1'b1;
          else                           credit[v] <= credit[v] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_inject_ni.sv
// Randomised and directed bench for pe_inject_ni against a queue-based cycle model.
module tb_pe_inject_ni;
  import pe_inject_ni_pkg::*;

  localparam int NV = 2, DEP = 4, CRED = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_cnt;
  logic        err;

  pe_inject_ni_if #(.VCH(NV)) bus ();

  pe_inject_ni #(.VCH(NV), .DEPTH(DEP), .CREDITS(CRED)) dut (
    .clk     (clk),
    .rst     (rst),
    .ni      (bus.slave),
    .pkt_cnt (pkt_cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one flit queue per VC plus credits, rr pointer and packet flags.
  logic [31:0] q [NV][$];
  int          cred [NV];
  bit          in_pkt [NV];
  int          rr, m_cnt;
  bit          m_err;
  bit          e_ovalid;
  logic [31:0] e_odata;
  int          e_ovch;

  int          cyc = 0, n_sent = 0, first_out = -1, first_in = 0;
  logic [31:0] outs [$];

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      q[v].delete();
      cred[v]   = CRED;
      in_pkt[v] = 1'b0;
    end
    rr = 0; m_cnt = 0; m_err = 1'b0; e_ovalid = 1'b0;
  endfunction

  function automatic logic [31:0] fl(input flit_type_e t, input int p);
    return {t, 30'(p)};
  endfunction

  function automatic bit model_room();
    for (int v = 0; v < NV; v++)
      if (DEP - q[v].size() < 2) return 1'b0;
    return 1'b1;
  endfunction

  // Called at a falling edge: check what the last rising edge produced, drive
  // this cycle's inputs, then advance the model to the next rising edge.
  task automatic step(input bit r, input bit rq, input bit iv, input int ch,
                      input logic [31:0] d, input logic [1:0] icr);
    int win;
    bit acc;
    logic [1:0] t;
    if (bus.ovalid === 1'b1) begin
      n_sent++;
      outs.push_back(32'(bus.ovch));
      if (first_out < 0) first_out = cyc;
    end
    chk("ovalid", 32'(bus.ovalid), 32'(e_ovalid));
    if (e_ovalid) begin
      chk("odata", bus.odata, e_odata);
      chk("ovch", 32'(bus.ovch), 32'(e_ovch));
    end
    chk("err", 32'(err), 32'(m_err));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));

    rst = r; bus.req = rq; bus.ivalid = iv; bus.ivch = ch[0:0];
    bus.idata = d; bus.icredit = icr;
    #1;
    chk("grt", 32'(bus.grt), 32'(rq && model_room()));

    if (r) begin
      model_reset();
    end else begin
      win = -1;
      for (int i = 0; i < NV; i++) begin
        int v = (rr + i) % NV;
        if (win < 0 && q[v].size() > 0 && cred[v] > 0) win = v;
      end
      acc = iv && ch < NV && (q[ch].size() < DEP || win == ch);
      e_ovalid = (win >= 0);
      if (win >= 0) begin
        e_odata = q[win].pop_front();
        e_ovch  = win;
        rr      = (win + 1) % NV;
        t       = e_odata[31:30];
        if (t == TYPE_TAIL || t == TYPE_HEADTAIL) m_cnt = (m_cnt + 1) % 65536;
      end
      for (int v = 0; v < NV; v++) begin
        if (win == v && !icr[v]) cred[v]--;
        else if (icr[v] && win != v) begin
          if (cred[v] == CRED) m_err = 1'b1;
          else                 cred[v]++;
        end
      end
      if (iv) begin
        if (!acc) m_err = 1'b1;
        else begin
          t = d[31:30];
          if (!in_pkt[ch] && !(t == TYPE_HEAD || t == TYPE_HEADTAIL)) m_err = 1'b1;
          if (in_pkt[ch] && !(t == TYPE_BODY || t == TYPE_TAIL))      m_err = 1'b1;
          in_pkt[ch] = (t == TYPE_HEAD || t == TYPE_BODY);
          q[ch].push_back(d);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input bit rq);
    for (int i = 0; i < n; i++) step(0, rq, 0, 0, 32'h0, 2'b00);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 32'h0, 2'b00);
    n_sent = 0; first_out = -1; outs.delete();
  endtask

  // PE-side flit scheduler for the protocol-following random phase.
  bit          s_v [3];
  logic [31:0] s_d [3];
  int          s_c [3];
  int          left [NV];
  int          owed [NV];
  int          seq = 0;

  initial begin
    logic [1:0] icr;
    bit rq, g;
    int vc, slot;
    flit_type_e ty;

    rst = 1'b1; bus.req = 1'b0; bus.ivalid = 1'b0; bus.ivch = '0;
    bus.idata = '0; bus.icredit = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then a single 4-flit packet on VC0.
    do_reset();
    step(0, 1, 0, 0, 32'h0, 2'b00);
    first_in = cyc;
    step(0, 1, 1, 0, fl(TYPE_HEAD, 1), 2'b00);
    step(0, 1, 1, 0, fl(TYPE_BODY, 2), 2'b00);
    step(0, 1, 1, 0, fl(TYPE_BODY, 3), 2'b00);
    step(0, 1, 1, 0, fl(TYPE_TAIL, 4), 2'b00);
    idle(5, 0);
    chk("latency", 32'(first_out - first_in), 32'd2);
    chk("single_sent", 32'(n_sent), 32'd4);
    chk("single_pkts", 32'(pkt_cnt), 32'd1);
    chk("single_err", 32'(err), 32'd0);

    // Alternating VC0/VC1 packets with credits returned after each send.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      icr = bus.ovalid ? (2'b01 << bus.ovch) : 2'b00;
      if (i < 6) begin
        ty = (i < 2) ? TYPE_HEAD : (i < 4) ? TYPE_BODY : TYPE_TAIL;
        step(0, 1, 1, i % 2, fl(ty, 16 + i), icr);
      end else begin
        step(0, 0, 0, 0, 32'h0, icr);
      end
    end
    chk("ilv_count", 32'(outs.size()), 32'd6);
    for (int i = 0; i < 6 && i < outs.size(); i++) chk("ilv_vc", outs[i], 32'(i % 2));
    chk("ilv_pkts", 32'(pkt_cnt), 32'd2);

    // Credit stall on VC1: only 4 of 6 flits leave until a credit returns.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ty = (i == 0) ? TYPE_HEAD : (i == 5) ? TYPE_TAIL : TYPE_BODY;
      step(0, 1, 1, 1, fl(ty, 32 + i), 2'b00);
    end
    idle(6, 1);
    chk("stall_sent", 32'(n_sent), 32'd4);
    step(0, 1, 0, 0, 32'h0, 2'b10);
    idle(4, 1);
    chk("stall_release", 32'(n_sent), 32'd5);

    // Overflow: drain VC0 credits, then push 5 flits into a 4-deep FIFO.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, fl(TYPE_HEADTAIL, 48 + i), 2'b00);
    idle(4, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, fl(TYPE_HEADTAIL, 52 + i), 2'b00);
    idle(1, 0);
    chk("ovf_pre_err", 32'(err), 32'd0);
    step(0, 0, 1, 0, fl(TYPE_HEADTAIL, 56), 2'b00);
    idle(1, 0);
    chk("ovf_err", 32'(err), 32'd1);
    idle(4, 0);
    chk("ovf_err_held", 32'(err), 32'd1);

    // Protocol errors: BODY on an idle VC, HEAD after HEAD.
    do_reset();
    step(0, 0, 1, 0, fl(TYPE_BODY, 60), 2'b00);
    idle(3, 0);
    chk("body_idle_err", 32'(err), 32'd1);
    chk("body_idle_sent", 32'(n_sent), 32'd1);
    do_reset();
    step(0, 0, 1, 1, fl(TYPE_HEAD, 61), 2'b00);
    idle(1, 0);
    chk("head_ok", 32'(err), 32'd0);
    step(0, 0, 1, 1, fl(TYPE_HEAD, 62), 2'b00);
    idle(1, 0);
    chk("head_head_err", 32'(err), 32'd1);

    // Reset mid-packet; afterwards the full credit budget is back.
    do_reset();
    step(0, 1, 1, 0, fl(TYPE_HEAD, 70), 2'b00);
    step(0, 1, 1, 0, fl(TYPE_BODY, 71), 2'b00);
    do_reset();
    chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
    chk("rst_pkts", 32'(pkt_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, fl(TYPE_HEADTAIL, 72 + i), 2'b00);
    idle(5, 0);
    chk("rst_credits", 32'(n_sent), 32'd4);
    chk("rst_err", 32'(err), 32'd0);

    // Random PE following req/grt with 1-2 cycle flit delay; router returns credits.
    do_reset();
    for (int i = 0; i < 3; i++) s_v[i] = 1'b0;
    for (int v = 0; v < NV; v++) begin left[v] = 0; owed[v] = 0; end
    for (int n = 0; n < 800; n++) begin
      if (bus.ovalid === 1'b1) owed[bus.ovch]++;
      icr = 2'b00;
      for (int v = 0; v < NV; v++)
        if (owed[v] > 0 && $urandom_range(3) != 0) begin icr[v] = 1'b1; owed[v]--; end
      rq = (n < 760) && ($urandom_range(3) != 0);
      g  = rq && model_room();
      if (g) begin
        vc = $urandom_range(NV - 1);
        if (left[vc] == 0) begin
          left[vc] = $urandom_range(3);
          ty = (left[vc] == 0) ? TYPE_HEADTAIL : TYPE_HEAD;
        end else begin
          left[vc]--;
          ty = (left[vc] == 0) ? TYPE_TAIL : TYPE_BODY;
        end
        slot = (!s_v[1] && $urandom_range(1) == 1) ? 1 : 2;
        s_v[slot] = 1'b1; s_c[slot] = vc; s_d[slot] = fl(ty, seq++);
      end
      step(0, rq, s_v[0], s_c[0], s_d[0], icr);
      for (int i = 0; i < 2; i++) begin
        s_v[i] = s_v[i+1]; s_c[i] = s_c[i+1]; s_d[i] = s_d[i+1];
      end
      s_v[2] = 1'b0;
    end

    // Unconstrained abuse: random types, VCs and credit pulses.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      ty = flit_type_e'($urandom_range(3));
      icr = 2'($urandom_range(3)) & 2'($urandom_range(3));
      step(0, $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(NV - 1),
           fl(ty, seq++), icr);
    end
    idle(4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
